// File: rtl/trdb_pkg.sv
// ============================================================================
// Module      : trdb_pkg
// Description : Shared trace-debugger types and constants for the packet path
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trdb_pkg;

    localparam int XLEN      = 32;
    localparam int PKT_LEN_W = 8;
    localparam int PKT_FMT_W = 2;

    // Header word layout; bits above the format field are ignored.
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_FMT_LSB = HDR_LEN_LSB + PKT_LEN_W;
    localparam int HDR_W       = HDR_FMT_LSB + PKT_FMT_W;

    typedef enum logic [1:0] {
        DF_IDLE    = 2'd0,
        DF_COLLECT = 2'd1,
        DF_PEND    = 2'd2
    } deframer_state_e;

    typedef enum logic [PKT_FMT_W-1:0] {
        PKT_FMT_0 = 2'd0,
        PKT_FMT_1 = 2'd1,
        PKT_FMT_2 = 2'd2,
        PKT_FMT_3 = 2'd3
    } pkt_format_e;

    function automatic logic [PKT_LEN_W-1:0] hdr_len(input logic [HDR_W-1:0] hdr);
        return hdr[HDR_LEN_LSB +: PKT_LEN_W];
    endfunction

    function automatic pkt_format_e hdr_fmt(input logic [HDR_W-1:0] hdr);
        return pkt_format_e'(hdr[HDR_FMT_LSB +: PKT_FMT_W]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/trdb_deframer_obuf.sv
// ============================================================================
// Module      : trdb_deframer_obuf
// Description : One-entry valid/ready holding register for a reassembled packet
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trdb_deframer_obuf
    import trdb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_WORDS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [MAX_WORDS*XLEN-1:0] pkt_i,
    input  logic [PKT_LEN_W-1:0]      len_i,
    input  pkt_format_e               fmt_i,
    input  logic                      ready_i,
    output logic                      valid_o,
    output logic [MAX_WORDS*XLEN-1:0] pkt_o,
    output logic [PKT_LEN_W-1:0]      len_o,
    output logic [PKT_FMT_W-1:0]      fmt_o
);

    logic                      valid_q, valid_d;
    logic [MAX_WORDS*XLEN-1:0] pkt_q, pkt_d;
    logic [PKT_LEN_W-1:0]      len_q, len_d;
    pkt_format_e               fmt_q, fmt_d;

    // Load has priority over drain so a same-cycle swap keeps valid high.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        len_d   = len_q;
        fmt_d   = fmt_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
            len_d   = len_i;
            fmt_d   = fmt_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
            len_q   <= '0;
            fmt_q   <= PKT_FMT_0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
            len_q   <= len_d;
            fmt_q   <= fmt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;
    assign len_o   = len_q;
    assign fmt_o   = fmt_q;

endmodule

`default_nettype wire

// File: rtl/trdb_packet_deframer.sv
// ============================================================================
// Module      : trdb_packet_deframer
// Description : Reassembles header+payload trace words into packets with a
//               one-entry output buffer and overflow drop accounting.
//               Optional macro TRDB_DEFRAMER_STATS_EN enables drop/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trdb_packet_deframer
    import trdb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_WORDS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [XLEN-1:0]           packet_word_i,
    input  logic                      packet_word_valid_i,
    output logic [MAX_WORDS*XLEN-1:0] packet_o,
    output logic [PKT_LEN_W-1:0]      packet_len_o,
    output logic [PKT_FMT_W-1:0]      packet_format_o,
    output logic                      packet_valid_o,
    input  logic                      packet_ready_i,
    output logic                      hdr_error_o,
    output logic [15:0]               drop_cnt_o,
    output logic [15:0]               err_cnt_o,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    deframer_state_e           state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PKT_LEN_W-1:0]      len_q, len_d;
    pkt_format_e               fmt_q, fmt_d;
    logic [MAX_WORDS*XLEN-1:0] asm_q, asm_d;
    logic                      load_q, load_d;
    logic                      hdr_error_q, hdr_error_d;
    logic                      busy_q, busy_d;

    logic                      obuf_valid;
    logic                      obuf_load;
    logic                      obuf_free;
    logic                      hdr_accept;
    logic                      drop_inc;
    logic                      err_inc;
    logic [PKT_LEN_W-1:0]      w_hdr_len;
    logic                      w_hdr_ok;

    assign w_hdr_len = hdr_len(packet_word_i[HDR_W-1:0]);
    assign w_hdr_ok  = (w_hdr_len != '0) && (w_hdr_len <= PKT_LEN_W'(MAX_WORDS));
    assign obuf_free = !obuf_valid || packet_ready_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        fmt_d       = fmt_q;
        asm_d       = asm_q;
        load_d      = 1'b0;
        hdr_error_d = 1'b0;
        hdr_accept  = 1'b0;
        drop_inc    = 1'b0;
        err_inc     = 1'b0;
        obuf_load   = load_q;

        case (state_q)
            DF_IDLE: begin
                hdr_accept = packet_word_valid_i;
            end
            DF_COLLECT: begin
                if (packet_word_valid_i) begin
                    for (int i = 0; i < MAX_WORDS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            asm_d[i*XLEN +: XLEN] = packet_word_i;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (PKT_LEN_W'(cnt_q) == len_q - 1'b1) begin
                        // Copy into the output buffer happens on the next edge.
                        if (obuf_free) begin
                            load_d  = 1'b1;
                            state_d = DF_IDLE;
                        end else begin
                            state_d = DF_PEND;
                        end
                    end
                end
            end
            DF_PEND: begin
                // The buffer is known full here, so ready alone means it drains.
                if (packet_ready_i) begin
                    obuf_load = 1'b1;
                    state_d   = DF_IDLE;
                end else if (packet_word_valid_i) begin
                    drop_inc = 1'b1;
                end
                hdr_accept = packet_word_valid_i;
            end
            default: begin
                state_d = DF_IDLE;
            end
        endcase

        if (hdr_accept) begin
            if (w_hdr_ok) begin
                len_d   = w_hdr_len;
                fmt_d   = hdr_fmt(packet_word_i[HDR_W-1:0]);
                asm_d   = '0;
                cnt_d   = '0;
                state_d = DF_COLLECT;
            end else begin
                hdr_error_d = 1'b1;
                err_inc     = 1'b1;
                state_d     = DF_IDLE;
            end
        end

        busy_d = (state_d != DF_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= DF_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            fmt_q       <= PKT_FMT_0;
            asm_q       <= '0;
            load_q      <= 1'b0;
            hdr_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            fmt_q       <= fmt_d;
            asm_q       <= asm_d;
            load_q      <= load_d;
            hdr_error_q <= hdr_error_d;
            busy_q      <= busy_d;
        end
    end

`ifdef TRDB_DEFRAMER_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign err_cnt_o  = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = drop_inc ^ err_inc;
    assign drop_cnt_o   = '0;
    assign err_cnt_o    = '0;
`endif

    trdb_deframer_obuf #(
        .XLEN      (XLEN),
        .MAX_WORDS (MAX_WORDS)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (obuf_load),
        .pkt_i   (asm_q),
        .len_i   (len_q),
        .fmt_i   (fmt_q),
        .ready_i (packet_ready_i),
        .valid_o (obuf_valid),
        .pkt_o   (packet_o),
        .len_o   (packet_len_o),
        .fmt_o   (packet_format_o)
    );

    assign packet_valid_o = obuf_valid;
    assign hdr_error_o    = hdr_error_q;
    assign busy_o         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_trdb_packet_deframer.sv
// ============================================================================
// Module      : tb_trdb_packet_deframer
// Description : Directed self-checking bench for trdb_packet_deframer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trdb_packet_deframer;
    import trdb_pkg::*;

    localparam int TB_XLEN  = 32;
    localparam int TB_WORDS = 4;
    localparam int PW       = TB_XLEN * TB_WORDS;

`ifdef TRDB_DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   packet_word_i = '0;
    logic          packet_word_valid_i = 1'b0;
    logic [PW-1:0] packet_o;
    logic [7:0]    packet_len_o;
    logic [1:0]    packet_format_o;
    logic          packet_valid_o;
    logic          packet_ready_i = 1'b0;
    logic          hdr_error_o;
    logic [15:0]   drop_cnt_o;
    logic [15:0]   err_cnt_o;
    logic          busy_o;

    int tests = 0;
    int fails = 0;

    trdb_packet_deframer #(.XLEN(TB_XLEN), .MAX_WORDS(TB_WORDS)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .packet_word_i       (packet_word_i),
        .packet_word_valid_i (packet_word_valid_i),
        .packet_o            (packet_o),
        .packet_len_o        (packet_len_o),
        .packet_format_o     (packet_format_o),
        .packet_valid_o      (packet_valid_o),
        .packet_ready_i      (packet_ready_i),
        .hdr_error_o         (hdr_error_o),
        .drop_cnt_o          (drop_cnt_o),
        .err_cnt_o           (err_cnt_o),
        .busy_o              (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hdr(input int len, input int fmt);
        return 32'hABCD_0000 | 32'(len & 8'hFF) | (32'(fmt & 3) << 8);
    endfunction

    function automatic logic [15:0] stat(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        packet_word_i       = w;
        packet_word_valid_i = 1'b1;
        tick();
        packet_word_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        packet_word_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tests++;
        if ({packet_valid_o, packet_o, packet_len_o, packet_format_o, hdr_error_o,
             drop_cnt_o, err_cnt_o, busy_o} !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b pkt=%h len=%0d fmt=%0d err=%b drop=%0d errs=%0d busy=%b, want all 0",
                     packet_valid_o, packet_o, packet_len_o, packet_format_o, hdr_error_o,
                     drop_cnt_o, err_cnt_o, busy_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [PW-1:0] exp;
        exp = {32'h0, 32'h0, 32'hB, 32'hA};
        do_reset();
        packet_ready_i = 1'b1;
        send(hdr(2, 1));
        tests++;
        if (busy_o !== 1'b1) begin
            fails++; $display("FAIL basic_busy: got %b want 1", busy_o);
        end
        send(32'hA);
        send(32'hB);
        tests++;
        if (packet_valid_o !== 1'b0) begin
            fails++; $display("FAIL basic_latency_early: valid=%b want 0", packet_valid_o);
        end
        tick();
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== exp || packet_len_o !== 8'd2 ||
            packet_format_o !== 2'd1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_pkt: valid=%b pkt=%h len=%0d fmt=%0d busy=%b, want 1 %h 2 1 0",
                     packet_valid_o, packet_o, packet_len_o, packet_format_o, busy_o, exp);
        end
        tick();
        tests++;
        if (packet_valid_o !== 1'b0) begin
            fails++; $display("FAIL basic_drain: valid=%b want 0", packet_valid_o);
        end
    endtask

    task automatic test_bad_header();
        do_reset();
        packet_ready_i = 1'b1;
        send(hdr(0, 0));
        tests++;
        if (hdr_error_o !== 1'b1 || err_cnt_o !== stat(1) || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL bad_len0: err=%b cnt=%0d busy=%b, want 1 %0d 0", hdr_error_o, err_cnt_o, busy_o, stat(1));
        end
        tick();
        tests++;
        if (hdr_error_o !== 1'b0) begin
            fails++; $display("FAIL bad_pulse_width: err=%b want 0", hdr_error_o);
        end
        send(hdr(TB_WORDS + 1, 0));
        tests++;
        if (hdr_error_o !== 1'b1 || err_cnt_o !== stat(2)) begin
            fails++;
            $display("FAIL bad_len_over: err=%b cnt=%0d, want 1 %0d", hdr_error_o, err_cnt_o, stat(2));
        end
        send(hdr(1, 2));
        send(32'h5);
        tick();
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== PW'(32'h5) || packet_len_o !== 8'd1 ||
            packet_format_o !== 2'd2 || hdr_error_o !== 1'b0) begin
            fails++;
            $display("FAIL bad_resync: valid=%b pkt=%h len=%0d fmt=%0d err=%b, want 1 5 1 2 0",
                     packet_valid_o, packet_o, packet_len_o, packet_format_o, hdr_error_o);
        end
    endtask

    task automatic test_max_len();
        logic [PW-1:0] exp;
        exp = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        do_reset();
        packet_ready_i = 1'b1;
        send(hdr(TB_WORDS, 3));
        send(32'hAAAA_0001);
        send(32'hBBBB_0002);
        send(32'hCCCC_0003);
        send(32'hDDDD_0004);
        tick();
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== exp || packet_len_o !== 8'd4 ||
            packet_format_o !== 2'd3) begin
            fails++;
            $display("FAIL max_len: valid=%b pkt=%h len=%0d fmt=%0d, want 1 %h 4 3",
                     packet_valid_o, packet_o, packet_len_o, packet_format_o, exp);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        packet_ready_i = 1'b0;
        send(hdr(1, 0)); send(32'h1);
        send(hdr(1, 0)); send(32'h2);
        tick();
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== PW'(32'h1) || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_hold: valid=%b pkt=%h busy=%b, want 1 1 1", packet_valid_o, packet_o, busy_o);
        end
        send(hdr(1, 0));
        tests++;
        if (drop_cnt_o !== stat(1) || packet_o !== PW'(32'h1) || packet_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drop: drop=%0d pkt=%h valid=%b, want %0d 1 1", drop_cnt_o, packet_o, packet_valid_o, stat(1));
        end
        send(32'h3);
        packet_ready_i = 1'b1;
        tick();
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== PW'(32'h3) || drop_cnt_o !== stat(1)) begin
            fails++;
            $display("FAIL ovf_next: valid=%b pkt=%h drop=%0d, want 1 3 %0d", packet_valid_o, packet_o, drop_cnt_o, stat(1));
        end
        tick();
        tests++;
        if (packet_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL ovf_empty: valid=%b busy=%b want 0 0", packet_valid_o, busy_o);
        end
    endtask

    task automatic test_transfer_wins();
        do_reset();
        packet_ready_i = 1'b0;
        send(hdr(1, 0)); send(32'h1);
        send(hdr(1, 0)); send(32'h2);
        packet_ready_i = 1'b1;
        send(hdr(1, 0));
        packet_ready_i = 1'b0;
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== PW'(32'h2) || drop_cnt_o !== 16'd0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL xfer_wins: valid=%b pkt=%h drop=%0d busy=%b, want 1 2 0 1",
                     packet_valid_o, packet_o, drop_cnt_o, busy_o);
        end
        send(32'h3);
        packet_ready_i = 1'b1;
        tick();
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== PW'(32'h3) || drop_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL xfer_next: valid=%b pkt=%h drop=%0d, want 1 3 0", packet_valid_o, packet_o, drop_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        packet_ready_i = 1'b1;
        send(hdr(3, 0)); send(32'h11); send(32'h22);
        do_reset();
        tests++;
        if (busy_o !== 1'b0 || packet_valid_o !== 1'b0) begin
            fails++; $display("FAIL rst_mid_idle: busy=%b valid=%b want 0 0", busy_o, packet_valid_o);
        end
        send(hdr(1, 1)); send(32'h7);
        tick();
        tests++;
        if (packet_valid_o !== 1'b1 || packet_o !== PW'(32'h7) || packet_len_o !== 8'd1 ||
            drop_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid_pkt: valid=%b pkt=%h len=%0d drop=%0d errs=%0d, want 1 7 1 0 0",
                     packet_valid_o, packet_o, packet_len_o, drop_cnt_o, err_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]   words [9];
        logic [PW-1:0] exp_pkt [4];
        logic [7:0]    exp_len [4];
        int            got;
        words   = '{hdr(1, 0), 32'h10, hdr(2, 1), 32'h20, 32'h21, hdr(1, 2), 32'h30, hdr(1, 3), 32'h40};
        exp_pkt = '{PW'(32'h10), PW'(64'h21_0000_0020), PW'(32'h30), PW'(32'h40)};
        exp_len = '{8'd1, 8'd2, 8'd1, 8'd1};
        got = 0;
        do_reset();
        packet_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 9) send(words[i]);
            else tick();
            if (packet_valid_o === 1'b1) begin
                tests++;
                if (got >= 4 || packet_o !== exp_pkt[got] || packet_len_o !== exp_len[got]) begin
                    fails++;
                    $display("FAIL b2b_pkt%0d: pkt=%h len=%0d, want %h %0d", got, packet_o, packet_len_o,
                             exp_pkt[got % 4], exp_len[got % 4]);
                end
                got++;
            end
        end
        tests++;
        if (got !== 4 || drop_cnt_o !== 16'd0) begin
            fails++; $display("FAIL b2b_count: got=%0d drop=%0d, want 4 0", got, drop_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_max_len();
        test_overflow();
        test_transfer_wins();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trdb_packet_deframer.md
# trdb_packet_deframer

Receiving end of the trace debugger's packet word stream. It samples `packet_word`/`packet_word_valid` words, parses each header word, and reassembles payload words into complete trace packets. Complete packets are presented on a valid/ready output for the host-side sink or the testbench scoreboard. The input has no backpressure, so the block double-buffers packets and counts what it must drop.

## Interface
Parameters:
- `XLEN`, 32, word width; must match `trdb_pkg::XLEN`.
- `MAX_WORDS`, 4, maximum payload words per packet (1..255).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, asynchronous, active-high.
- `packet_word_i`  in  XLEN  word from the trace debugger.
- `packet_word_valid_i`  in  1  word is valid this cycle; no backpressure.
- `packet_o`  out  MAX_WORDS*XLEN  payload; word 0 in the LSBs; unused words are zero.
- `packet_len_o`  out  8  payload word count.
- `packet_format_o`  out  2  format field from the header.
- `packet_valid_o`  out  1  packet available.
- `packet_ready_i`  in  1  sink accepts the packet; transfer when valid && ready.
- `hdr_error_o`  out  1  one-cycle pulse on an illegal header.
- `drop_cnt_o`  out  16  packets dropped because of overflow; saturating.
- `err_cnt_o`  out  16  illegal headers; saturating.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- Header word: `[7:0]` = len (payload words), `[9:8]` = format, `[XLEN-1:10]` = ignored.
- Only cycles with `packet_word_valid_i`=1 consume a word. Idle cycles between words are legal anywhere.
- FSM states:
  - IDLE: the next valid word is a header.
    - 1 ≤ len ≤ MAX_WORDS: latch len/format, clear the assembly register and word counter, go to COLLECT.
    - Otherwise: pulse `hdr_error_o`, increment `err_cnt_o`, stay in IDLE. This resynchronises on the next word.
  - COLLECT: store each valid word at index `cnt`, then `cnt++`. On the word where `cnt == len-1`:
    - If the output buffer is empty or being drained this cycle, transfer next cycle and go to IDLE.
    - Else go to PEND.
  - PEND: the assembled packet waits in the assembly register.
    - Output buffer frees (handshake): transfer, go to IDLE.
    - A valid word arrives before that: the pending packet is dropped and `drop_cnt_o` increments. The word is processed as an IDLE header in the same cycle.
    - Both in the same cycle: the transfer wins and nothing is dropped. The word is processed as a header.
- Output buffer (`trdb_deframer_obuf`) is a one-entry register.
  - `packet_valid_o` is set on load and cleared on handshake.
  - A load and a handshake in the same cycle leave valid=1 with the new contents.
  - Contents must stay stable while valid && !ready.
- Counters saturate at 16'hFFFF and never wrap.
- Reset mid-packet: partial packet discarded, FSM to IDLE, output buffer emptied. The first valid word after deassertion is treated as a header.
- `cnt` width is `$clog2(MAX_WORDS+1)`. len is compared at 8 bits with no truncation.

## Timing
- Reset values: `packet_valid_o`=0, `packet_o`=0, `packet_len_o`=0, `packet_format_o`=0, `hdr_error_o`=0, `drop_cnt_o`=0, `err_cnt_o`=0, `busy_o`=0.
- Latency: last payload word sampled at edge N → `packet_valid_o`=1 after edge N+1, when the buffer is free.
- `hdr_error_o` is high for exactly the cycle after the bad header is sampled.
- Throughput: back-to-back packets at one word per cycle are sustained with no drops while `packet_ready_i`=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `TRDB_DEFRAMER_STATS_EN`
  - Defined: the drop and error counters are implemented as specified above.
  - Undefined: both counters are removed and `drop_cnt_o`/`err_cnt_o` are tied to 0. `hdr_error_o` and the drop behaviour are unchanged.

## Structure
- `trdb_pkg` gains:
  - `PKT_LEN_W` = 8 and `PKT_FMT_W` = 2.
  - The header field positions.
  - An enum type for the deframer FSM states.
  - A `pkt_format_e` typedef for the two-bit format.
- Sub-module `trdb_deframer_obuf`: one-entry valid/ready holding register for packet, len and format.

## Test plan
- Header len=2 fmt=1, then payload 0xA, 0xB with ready=1 → one cycle after 0xB: valid=1, `packet_o` word0=0xA, word1=0xB, words 2–3 = 0, len=2, format=1.
- Header len=0, then header len=1 with payload 0x5 → `hdr_error_o` pulses once, err_cnt=1, then a packet with len=1 and 0x5 is delivered.
- Two 1-word packets 0x1 and 0x2 back-to-back with ready=0 throughout, then a third header → packet 0x1 held in the buffer, packet 0x2 dropped when the third header arrives, drop_cnt=1.
- Same as the previous scenario, but ready=1 in the same cycle the third header arrives → no drop, packet 0x2 moves into the buffer, drop_cnt=0.
- Reset asserted after 2 of 3 payload words, then a 1-word packet 0x7 → only 0x7 is delivered, all counters 0.
- Build without `TRDB_DEFRAMER_STATS_EN` and rerun the overflow scenario → same packet behaviour, `drop_cnt_o`=0.
